// File: rtl/im_loader_pkg.sv
// im_loader_pkg: loader state encodings, IM geometry and header decode helper
package im_loader_pkg;
  localparam int IM_ADDR_W = 10;
  localparam int IM_BYTES = 1024;
  localparam int IM_WORDS = IM_BYTES / 4;
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR} state_t;
  function automatic state_t hdr_next(input logic [15:0] n, input int max_words);
    return n == 16'd0 ? DONE : (32'(n) > max_words ? ERR : DATA);
  endfunction
endpackage

// File: rtl/im_loader_if.sv
// im_loader_if: byte stream in, IM word write port out
interface im_loader_if import im_loader_pkg::*; #(parameter int ADDR_W = IM_ADDR_W);
  logic in_valid;
  logic in_ready;
  logic [7:0] in_data;
  logic im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0] im_wdata;
  modport master (output in_valid, in_data, input in_ready, im_we, im_addr, im_wdata);
  modport slave (input in_valid, in_data, output in_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/im_word_pack.sv
// im_word_pack: little-endian byte-to-word assembler
module im_word_pack (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic [1:0]  byte_idx,
  output logic        word_ready
);
  logic [31:0] word_q, word_d;
  logic [1:0] idx_q, idx_d;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign word_d[8*i +: 8] = load && idx_q == 2'(i) ? in_byte : word_q[8*i +: 8];
  end
  assign idx_d = load ? idx_q + 2'd1 : idx_q;
  assign word = word_d;
  assign byte_idx = idx_q;
  assign word_ready = load && idx_q == 2'd3;
  always_ff @(posedge clk)
    if (clr) begin
      word_q <= '0;
      idx_q <= '0;
    end else begin
      word_q <= word_d;
      idx_q <= idx_d;
    end
endmodule

// File: rtl/im_loader.sv
// im_loader: framed byte stream to IM word writer with CPU hold
module im_loader import im_loader_pkg::*; #(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int MAX_WORDS = IM_WORDS
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  im_loader_if.slave bus,
  output logic cpu_hold,
  output logic done,
  output logic error
);
  state_t state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [ADDR_W-2:0] word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, pk_word;
  logic [1:0] pk_idx;
  logic pk_ready, xfer, load, go;
  assign go = start && state_q inside {IDLE, DONE, ERR};
  assign xfer = bus.in_valid && bus.in_ready;
  assign load = xfer && state_q == DATA;
  im_word_pack u_pack (
    .clk(clk),
    .clr(rst || go),
    .load(load),
    .in_byte(bus.in_data),
    .word(pk_word),
    .byte_idx(pk_idx),
    .word_ready(pk_ready)
  );
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_idx_d = word_idx_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = HDR_LO;
        count_d = '0;
        word_idx_d = '0;
      end
      HDR_LO: if (xfer) begin
        count_d[7:0] = bus.in_data;
        state_d = HDR_HI;
      end
      HDR_HI: if (xfer) begin
        count_d[15:8] = bus.in_data;
        state_d = hdr_next({bus.in_data, count_q[7:0]}, MAX_WORDS);
      end
      DATA: if (pk_ready && pk_idx == 2'd3) begin
        addr_d = {word_idx_q[ADDR_W-3:0], 2'b00};
        wdata_d = pk_word;
        state_d = WRITE;
      end
      WRITE: begin
        word_idx_d = word_idx_q + (ADDR_W-1)'(1);
        state_d = 16'(word_idx_q) + 16'd1 == count_q ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      word_idx_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_idx_q <= word_idx_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  // rst gates the strobe so a reset landing on WRITE never commits the word
  assign bus.im_we = state_q == WRITE && !rst;
  assign bus.in_ready = state_q inside {HDR_LO, HDR_HI, DATA};
  assign bus.im_addr = addr_q;
  assign bus.im_wdata = wdata_q;
  assign cpu_hold = state_q != DONE;
  assign done = state_q == DONE;
  assign error = state_q == ERR;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed checks of framing, word assembly, errors and reset
module tb_im_loader;
  logic clk = 0, rst = 1, start = 0;
  logic cpu_hold, done, error;
  int errors = 0, checks = 0, bad_ready = 0, bad_width = 0;
  logic we_prev = 0;
  logic [9:0] wr_addr[$];
  logic [31:0] wr_data[$];
  im_loader_if bus ();
  im_loader dut (.clk(clk), .rst(rst), .start(start), .bus(bus), .cpu_hold(cpu_hold), .done(done), .error(error));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.im_we) begin
      wr_addr.push_back(bus.im_addr);
      wr_data.push_back(bus.im_wdata);
    end
    if (bus.im_we && bus.in_ready) bad_ready++;
    if (bus.im_we && we_prev) bad_width++;
    we_prev = bus.im_we;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap = 0);
    int n = 0;
    bus.in_valid = 0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1;
    bus.in_data = b;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'(n), 0);
    @(negedge clk);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask
  task automatic go();
    wr_addr.delete();
    wr_data.delete();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_end(input string tag);
    int n = 0;
    bus.in_valid = 0;
    while (!done && !error && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check(tag, 32'(n), 0);
  endtask
  initial begin
    int mism;
    logic [31:0] w;
    bus.in_valid = 0;
    bus.in_data = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_im_we", bus.im_we, 0);
    check("rst_im_addr", bus.im_addr, 0);
    check("rst_im_wdata", bus.im_wdata, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    rst = 0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 0);
    // empty image finishes right after the header
    go();
    send(8'h00);
    send(8'h00);
    bus.in_valid = 0;
    check("t1_done", done, 1);
    check("t1_cpu_hold", cpu_hold, 0);
    check("t1_in_ready", bus.in_ready, 0);
    check("t1_writes", wr_addr.size(), 0);
    go();
    check("t2_done_clear", done, 0);
    check("t2_hold_back", cpu_hold, 1);
    send(8'h02); send(8'h00);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    wait_end("t2_timeout");
    check("t2_nwrites", wr_addr.size(), 2);
    check("t2_addr0", wr_addr[0], 0);
    check("t2_data0", wr_data[0], 32'h12345678);
    check("t2_addr1", wr_addr[1], 4);
    check("t2_data1", wr_data[1], 32'hDEADBEEF);
    check("t2_done", done, 1);
    // stalls between bytes must neither drop nor repeat a byte
    go();
    send(8'h01, 1); send(8'h00, 0);
    send(8'h11, 2); send(8'h22, 0); send(8'h33, 3); send(8'h44, 1);
    wait_end("t3_timeout");
    check("t3_nwrites", wr_addr.size(), 1);
    check("t3_addr", wr_addr[0], 0);
    check("t3_data", wr_data[0], 32'h44332211);
    check("t3_done", done, 1);
    go();
    send(8'h01); send(8'h01);
    bus.in_valid = 0;
    check("t4_error", error, 1);
    check("t4_cpu_hold", cpu_hold, 1);
    check("t4_done", done, 0);
    check("t4_in_ready", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    check("t4_nwrites", wr_addr.size(), 0);
    go();
    check("t4_error_clear", error, 0);
    send(8'h01); send(8'h00);
    send_word(32'hDDCCBBAA);
    wait_end("t4b_timeout");
    check("t4b_nwrites", wr_addr.size(), 1);
    check("t4b_addr", wr_addr[0], 0);
    check("t4b_data", wr_data[0], 32'hDDCCBBAA);
    check("t4b_error", error, 0);
    check("t4b_done", done, 1);
    // full memory: 256 words, last at 0x3FC
    go();
    send(8'h00); send(8'h01);
    for (int i = 0; i < 256; i++) send_word({8'(i), ~8'(i), 8'h5A, 8'(i)});
    wait_end("t5_timeout");
    check("t5_nwrites", wr_addr.size(), 256);
    mism = 0;
    for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
      w = {8'(i), ~8'(i), 8'h5A, 8'(i)};
      if (wr_addr[i] !== 10'(4 * i) || wr_data[i] !== w) mism++;
    end
    check("t5_word_mismatches", mism, 0);
    check("t5_last_addr", wr_addr[255], 10'h3FC);
    check("t5_done", done, 1);
    go();
    send(8'h02); send(8'h00);
    send_word(32'h04030201);
    send(8'h05); send(8'h06);
    bus.in_valid = 0;
    rst = 1;
    @(negedge clk);
    check("t6_in_ready", bus.in_ready, 0);
    check("t6_cpu_hold", cpu_hold, 1);
    check("t6_done", done, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    check("t6_in_ready_idle", bus.in_ready, 0);
    check("t6_nwrites", wr_addr.size(), 1);
    check("t6_addr", wr_addr[0], 0);
    check("t6_data", wr_data[0], 32'h04030201);
    go();
    send(8'h01); send(8'h00);
    send_word(32'hD4C3B2A1);
    wait_end("t6b_timeout");
    check("t6b_nwrites", wr_addr.size(), 1);
    check("t6b_addr", wr_addr[0], 0);
    check("t6b_data", wr_data[0], 32'hD4C3B2A1);
    check("t6b_done", done, 1);
    check("we_while_ready", bad_ready, 0);
    check("we_pulse_width", bad_width, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
